// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline register with a 2-entry skid buffer, flush and
// saturating stall/bubble counters.
module pipe_stage_elastic #(
    parameter int                CTRL_W   = 16,
    parameter int                DATA_W   = 96,
    parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}},
    parameter int                CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);
    logic              m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
    logic [CNT_W-1:0]  stall_q, stall_d, bubble_q, bubble_d;
    logic              push, pop;

    assign in_ready   = !s_valid_q && !Reset;
    assign push       = in_valid && in_ready;
    assign pop        = m_valid_q && out_ready;
    assign out_valid  = m_valid_q;
    assign out_ctrl   = m_ctrl_q;
    assign out_data   = m_data_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;
        if (Flush) begin
            m_valid_d = 1'b0;
            m_ctrl_d  = CTRL_RST;
            s_valid_d = 1'b0;
            s_ctrl_d  = CTRL_RST;
        end else if (pop && !push) begin
            m_valid_d = s_valid_q;
            m_ctrl_d  = s_valid_q ? s_ctrl_q : CTRL_RST;
            m_data_d  = s_valid_q ? s_data_q : m_data_q;
            s_valid_d = 1'b0;
            s_ctrl_d  = CTRL_RST;
        end else if (push && (pop || !m_valid_q)) begin
            m_valid_d = 1'b1;
            m_ctrl_d  = in_ctrl;
            m_data_d  = in_data;
        end else if (push) begin
            s_valid_d = 1'b1;
            s_ctrl_d  = in_ctrl;
            s_data_d  = in_data;
        end
        // Counters saturate at all-ones rather than wrapping.
        stall_d  = stall_q + CNT_W'(m_valid_q && !out_ready && stall_q != '1);
        bubble_d = bubble_q + CNT_W'(!m_valid_q && bubble_q != '1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            m_valid_q <= 1'b0;
            m_ctrl_q  <= CTRL_RST;
            m_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_ctrl_q  <= CTRL_RST;
            s_data_q  <= '0;
            stall_q   <= '0;
            bubble_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_ctrl_q  <= m_ctrl_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_ctrl_q  <= s_ctrl_d;
            s_data_q  <= s_data_d;
            stall_q   <= stall_d;
            bubble_q  <= bubble_d;
        end
    end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed vector table, counter saturation and a random FIFO-scoreboard run.
module tb_pipe_stage_elastic;
    localparam logic [15:0] CRST = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1, fl = 1'b0, iv = 1'b1, ordy = 1'b1;
    logic [15:0] ictrl;
    logic [31:0] idata = 32'h99;
    logic        ir, ov, ir_s, ov_s;
    logic [15:0] octrl, octrl_s;
    logic [31:0] odata, odata_s;
    logic [15:0] st, bb;
    logic [3:0]  st_s, bb_s;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] cf(input logic [31:0] d);
        return d[15:0] ^ 16'h3C3C;
    endfunction

    assign ictrl = cf(idata);

    pipe_stage_elastic #(.CTRL_W(16), .DATA_W(32), .CTRL_RST(CRST), .CNT_W(16)) dut (
        .Clk(clk), .Reset(rst), .Flush(fl), .in_valid(iv), .in_ready(ir), .in_ctrl(ictrl),
        .in_data(idata), .out_valid(ov), .out_ready(ordy), .out_ctrl(octrl), .out_data(odata),
        .stall_cnt(st), .bubble_cnt(bb));

    pipe_stage_elastic #(.CTRL_W(16), .DATA_W(32), .CTRL_RST(CRST), .CNT_W(4)) dut_s (
        .Clk(clk), .Reset(rst), .Flush(fl), .in_valid(iv), .in_ready(ir_s), .in_ctrl(ictrl),
        .in_data(idata), .out_valid(ov_s), .out_ready(ordy), .out_ctrl(octrl_s), .out_data(odata_s),
        .stall_cnt(st_s), .bubble_cnt(bb_s));

    typedef struct {
        logic rst, fl, iv; logic [31:0] d; logic ordy;
        logic ov; logic [31:0] od; logic ir; int st, bb;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic r, f, v, input logic [31:0] d, input logic o,
                       input logic eov, input logic [31:0] eod, input logic eir, input int est, ebb);
        vq.push_back('{r, f, v, d, o, eov, eod, eir, est, ebb});
    endtask

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    logic [31:0] q[$];
    int          seq, stm, bbm;
    logic        push, pop, ok;

    initial begin
        //  rst fl iv data  ordy | ov  od     ir  stall bubble
        add(1, 0, 1, 32'h99, 1,   0, 32'h0,  0,  0, 0);
        add(1, 0, 1, 32'h99, 1,   0, 32'h0,  0,  0, 0);
        add(0, 0, 0, 32'h0,  1,   0, 32'h0,  1,  0, 1);
        for (int i = 1; i <= 8; i++) add(0, 0, 1, i, 1, 1, i, 1, 0, 2);
        add(0, 0, 0, 32'h0,  1,   0, 32'h8,  1,  0, 2);
        add(0, 0, 1, 32'hA,  1,   1, 32'hA,  1,  0, 3);
        add(0, 0, 1, 32'hB,  0,   1, 32'hA,  0,  1, 3);
        add(0, 0, 1, 32'hC,  0,   1, 32'hA,  0,  2, 3);
        add(0, 0, 1, 32'hC,  0,   1, 32'hA,  0,  3, 3);
        add(0, 0, 1, 32'hC,  1,   1, 32'hB,  1,  3, 3);
        add(0, 0, 1, 32'hC,  1,   1, 32'hC,  1,  3, 3);
        add(0, 0, 0, 32'h0,  1,   0, 32'hC,  1,  3, 3);
        add(0, 0, 1, 32'hE,  0,   1, 32'hE,  1,  3, 4);
        add(0, 0, 1, 32'hF,  0,   1, 32'hE,  0,  4, 4);
        add(0, 1, 1, 32'hD,  0,   0, 32'hE,  1,  5, 4);
        add(0, 0, 0, 32'h0,  1,   0, 32'hE,  1,  5, 5);
        add(0, 0, 1, 32'h10, 1,   1, 32'h10, 1,  5, 6);
        add(0, 1, 1, 32'h11, 0,   0, 32'h10, 1,  6, 6);
        add(0, 0, 0, 32'h0,  0,   0, 32'h10, 1,  6, 7);
        add(0, 0, 1, 32'h20, 0,   1, 32'h20, 1,  6, 8);
        add(0, 0, 1, 32'h21, 0,   1, 32'h20, 0,  7, 8);
        add(1, 0, 0, 32'h0,  0,   0, 32'h0,  0,  0, 0);
        add(0, 0, 0, 32'h0,  1,   0, 32'h0,  1,  0, 1);
        foreach (vq[i]) begin
            rst = vq[i].rst; fl = vq[i].fl; iv = vq[i].iv; idata = vq[i].d; ordy = vq[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), ov, vq[i].ov);
            chk($sformatf("v%0d out_data", i), odata, vq[i].od);
            chk($sformatf("v%0d out_ctrl", i), octrl, vq[i].ov ? cf(vq[i].od) : CRST);
            chk($sformatf("v%0d in_ready", i), ir, vq[i].ir);
            chk($sformatf("v%0d stall_cnt", i), st, vq[i].st);
            chk($sformatf("v%0d bubble_cnt", i), bb, vq[i].bb);
            chk($sformatf("v%0d bubble_cnt4", i), bb_s, vq[i].bb > 15 ? 15 : vq[i].bb);
        end
        rst = 0; fl = 0; iv = 0; ordy = 1;
        repeat (20) @(posedge clk);
        #1;
        chk("sat bubble_cnt16", bb, 21);
        chk("sat bubble_cnt4", bb_s, 15);
        @(posedge clk); #1;
        chk("sat bubble_cnt4 hold", bb_s, 15);
        chk("sat stall_cnt4", st_s, 0);
        seq = 100; stm = 0; bbm = 22;
        for (int c = 0; c < 1000; c++) begin
            iv = 1'($urandom_range(0, 1)); ordy = 1'($urandom_range(0, 3) != 0); idata = seq;
            #1;
            ok = (ir === (q.size() < 2)) && (ov === (q.size() > 0));
            if (q.size() > 0) ok = ok && odata === q[0] && octrl === cf(q[0]);
            else ok = ok && octrl === CRST;
            total++;
            if (ok) passed++;
            else $display("FAIL rand c%0d: got v=%0b r=%0b d=%0h c=%0h expected occ=%0d head=%0h",
                          c, ov, ir, odata, octrl, q.size(), q.size() > 0 ? q[0] : 32'h0);
            push = iv && q.size() < 2;
            pop = q.size() > 0 && ordy;
            if (q.size() > 0 && !ordy) stm++;
            if (q.size() == 0) bbm++;
            @(posedge clk);
            if (pop) void'(q.pop_front());
            if (push) begin q.push_back(seq); seq++; end
            #1;
        end
        chk("rand stall_cnt", st, stm);
        chk("rand bubble_cnt", bb, bbm);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline stage register for the MIPS datapath, replacing the fixed-width, always-advancing IF/ID, ID/EX, EX/MEM and MEM/WB latches. Each stage carries a control bundle and a data bundle between adjacent pipeline stages under a valid/ready handshake. A 2-entry skid buffer keeps `in_ready` registered, so stalls never form a combinational ready chain. The block adds flush (bubble insertion) with a programmable control reset value, and saturating stall/bubble counters for performance debug.

## Interface
- `CTRL_W`, default 16: control-signal bundle width (ALU op, RF/HI/LO enables, MEM enable/rw/size/sign, …).
- `DATA_W`, default 96: data bundle width (operands, PC, imm16, dest reg, …).
- `CTRL_RST`, default `{CTRL_W{1'b0}}`: control value presented during bubbles, flush and reset.
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `Clk`, in, 1: single clock, rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `Flush`, in, 1: synchronous squash of all held entries.
- `in_valid`, in, 1: upstream entry valid.
- `in_ready`, out, 1: stage can accept an entry.
- `in_ctrl`, in, CTRL_W: upstream control bundle.
- `in_data`, in, DATA_W: upstream data bundle.
- `out_valid`, out, 1: output entry valid.
- `out_ready`, in, 1: downstream accepts.
- `out_ctrl`, out, CTRL_W: control to next stage; equals CTRL_RST whenever `out_valid`=0.
- `out_data`, out, DATA_W: data to next stage.
- `stall_cnt`, out, CNT_W: cycles with `out_valid`=1 and `out_ready`=0.
- `bubble_cnt`, out, CNT_W: cycles with `out_valid`=0, outside reset.

## Operation
- Storage is main entry M (`m_valid`, `m_ctrl`, `m_data`) and skid entry S (`s_valid`, `s_ctrl`, `s_data`).
- Outputs are driven from M: `out_valid`=`m_valid`, `out_ctrl`=`m_ctrl`, `out_data`=`m_data`.
- `in_ready` = `!s_valid && !Reset`.
- push = `in_valid && in_ready`. pop = `m_valid && out_ready`.
- Per-edge update, highest priority first:
  - Reset: clear `m_valid` and `s_valid`; set both ctrl fields to CTRL_RST and both data fields to 0; clear both counters.
  - Flush: clear `m_valid` and `s_valid`; set both ctrl fields to CTRL_RST. Data fields hold. A push in the same cycle is discarded. Counters are not cleared.
  - pop, no push: if `s_valid`, M←S and S is cleared (ctrl←CTRL_RST). Otherwise `m_valid`←0 and `m_ctrl`←CTRL_RST.
  - push, no pop: if `!m_valid`, M←in. Otherwise S←in.
  - push and pop: M←in. S is empty here, since push requires `in_ready`.
  - neither: hold.
- Invariants:
  - `s_valid` implies `m_valid`.
  - Entries leave in the order they arrived.
  - No entry is lost or duplicated outside Flush and Reset.
- Counters: each increments by 1 per qualifying cycle and saturates at 2^CNT_W−1 with no wrap. Neither counts while Reset=1.
- `bubble_cnt` counts cycles where `out_valid`=0 at the start of the cycle, including cycles emptied by Flush.

## Timing
- Latency: an entry pushed at edge t is on `out_*` immediately after edge t (1 cycle) when M was empty or popped at t. It waits one more pop when it lands in S.
- Throughput: 1 entry/cycle with `out_ready` held high.
- `in_ready` falls in the cycle after S fills, so upstream may push one entry after downstream deasserts `out_ready`. S absorbs that entry.
- `in_ready` rises in the cycle after S drains.
- Values after a Reset edge: `out_valid`=0, `out_ctrl`=CTRL_RST, `out_data`=0, counters=0. `in_ready`=0 while Reset is high and 1 in the first cycle after Reset is released.
- Reset mid-stall discards both entries. Flush while full empties the stage in one cycle, and `in_ready`=1 on the next cycle.
- Simultaneous Reset and Flush behaves as Reset.

## Test plan
- **Reset:** assert Reset 2 cycles with `in_valid`=1 → `out_valid`=0, `out_ctrl`=CTRL_RST, `out_data`=0, `in_ready`=0 during reset, counters=0. `in_ready`=1 in the first cycle after release.
- **Streaming:** `out_ready`=1, push data 0x1..0x8 on consecutive cycles → outputs 0x1..0x8 on consecutive cycles, 1-cycle latency, `stall_cnt`=0.
- **Backpressure:** push 0xA, 0xB, 0xC back-to-back and drop `out_ready` the cycle 0xA appears → 0xA held, 0xB in S, `in_ready`=0, 0xC held upstream. Raise `out_ready` after 3 cycles → 0xA, 0xB, 0xC in order, `stall_cnt`=3.
- **Flush:** with both entries full, assert Flush plus a push of 0xD → next cycle `out_valid`=0, `out_ctrl`=CTRL_RST, 0xD not delivered, `in_ready`=1, `bubble_cnt` increments.
- **Saturation:** CNT_W=4 with `out_valid`=0 for 20 cycles → `bubble_cnt`=15 and held.
- **Randomised check:** random `in_valid`/`out_ready` for 1000 cycles against a FIFO scoreboard → in-order, no loss or duplication, `out_ctrl`=CTRL_RST on every invalid cycle.
